// File: rtl/fir_tap_serializer.sv
// Parallel-to-serial converter: captures one NB_TAPS-element vector and replays
// it element 0 first on a valid/ready serial stream, pulsing done_o after the last beat.
module fir_tap_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NB_TAPS    = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          clear_i,
  input  logic [NB_TAPS*DATA_WIDTH-1:0] par_data_i,
  input  logic                          par_valid_i,
  output logic                          par_ready_o,
  output logic [DATA_WIDTH-1:0]         ser_data_o,
  output logic                          ser_valid_o,
  input  logic                          ser_ready_i,
  output logic                          ser_last_o,
  output logic                          done_o
);

  // One extra counter bit keeps the width non-zero when NB_TAPS is 1.
  localparam int unsigned CNT_W = $clog2(NB_TAPS) + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NB_TAPS - 1);

  typedef enum logic {
    IDLE,
    SERIALIZE
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tap_buf_q [NB_TAPS];
  logic [DATA_WIDTH-1:0] tap_buf_d [NB_TAPS];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  is_last;

  assign par_ready_o = (state_q == IDLE);
  assign ser_valid_o = (state_q == SERIALIZE);
  assign is_last     = (cnt_q == LAST_IDX);
  assign ser_last_o  = ser_valid_o & is_last;
  assign done_o      = done_q;

  always_comb begin
    ser_data_o = '0;
    for (int unsigned k = 0; k < NB_TAPS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        ser_data_o = tap_buf_q[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    tap_buf_d = tap_buf_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    // Clear wins over any handshake in the same cycle and never raises done.
    if (clear_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      for (int unsigned k = 0; k < NB_TAPS; k++) begin
        tap_buf_d[k] = '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (par_valid_i) begin
            for (int unsigned k = 0; k < NB_TAPS; k++) begin
              tap_buf_d[k] = par_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
            cnt_d   = '0;
            state_d = SERIALIZE;
          end
        end
        SERIALIZE: begin
          if (ser_ready_i) begin
            if (is_last) begin
              cnt_d   = '0;
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < NB_TAPS; k++) begin
        tap_buf_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      tap_buf_q <= tap_buf_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_fir_tap_serializer.sv
// Randomized scoreboard bench for fir_tap_serializer (NB_TAPS=4) plus a
// directed check of a single-element instance.
module tb_fir_tap_serializer;

  localparam int DW = 32;
  localparam int NB = 4;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear_i = 1'b0;
  logic [NB*DW-1:0] par_data_i = '0;
  logic             par_valid_i = 1'b0;
  logic             par_ready_o;
  logic [DW-1:0]    ser_data_o;
  logic             ser_valid_o;
  logic             ser_ready_i = 1'b1;
  logic             ser_last_o;
  logic             done_o;

  logic [15:0] p1_data = '0;
  logic        p1_valid = 1'b0;
  logic        p1_ready;
  logic [15:0] s1_data;
  logic        s1_valid;
  logic        s1_ready = 1'b1;
  logic        s1_last;
  logic        done1;
  logic        clear1 = 1'b0;

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;

  logic [DW-1:0] exp_q[$];
  bit            m_busy = 1'b0;
  int            m_left = 0;
  bit            m_done = 1'b0;

  always #5 clk_i = ~clk_i;

  fir_tap_serializer #(.DATA_WIDTH(DW), .NB_TAPS(NB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .par_data_i(par_data_i), .par_valid_i(par_valid_i), .par_ready_o(par_ready_o),
    .ser_data_o(ser_data_o), .ser_valid_o(ser_valid_o), .ser_ready_i(ser_ready_i),
    .ser_last_o(ser_last_o), .done_o(done_o)
  );

  fir_tap_serializer #(.DATA_WIDTH(16), .NB_TAPS(1)) dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear1),
    .par_data_i(p1_data), .par_valid_i(p1_valid), .par_ready_o(p1_ready),
    .ser_data_o(s1_data), .ser_valid_o(s1_valid), .ser_ready_i(s1_ready),
    .ser_last_o(s1_last), .done_o(done1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream ready generator; mode 3 leaves ser_ready_i to the stimulus.
  always begin
    @(posedge clk_i);
    #1;
    case (rdy_mode)
      0: ser_ready_i = 1'b1;
      2: ser_ready_i = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Reference model: a vector occupies the block for exactly NB accepted beats,
  // elements leave in index order, done follows the final beat by one cycle.
  always @(negedge clk_i) begin
    bit nxt_done;
    if (!rst_ni) begin
      m_busy = 1'b0;
      m_left = 0;
      m_done = 1'b0;
      exp_q.delete();
    end
    checkOutput("par_ready", {31'd0, par_ready_o}, {31'd0, !m_busy});
    checkOutput("ser_valid", {31'd0, ser_valid_o}, {31'd0, m_busy});
    checkOutput("done", {31'd0, done_o}, {31'd0, m_done});
    if (m_busy) begin
      checkOutput("ser_last", {31'd0, ser_last_o}, {31'd0, (m_left == 1)});
      checkOutput("pending_count", exp_q.size(), m_left);
      if (exp_q.size() > 0) checkOutput("ser_data", ser_data_o, exp_q[0]);
    end
    if (rst_ni) begin
      nxt_done = 1'b0;
      if (clear_i) begin
        m_busy = 1'b0;
        m_left = 0;
        exp_q.delete();
      end else if (m_busy) begin
        if (ser_ready_i) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          m_left--;
          if (m_left == 0) begin
            m_busy   = 1'b0;
            nxt_done = 1'b1;
          end
        end
      end else if (par_valid_i) begin
        m_busy = 1'b1;
        m_left = NB;
      end
      m_done = nxt_done;
    end
  end

  task automatic applyStimulus(input logic [NB*DW-1:0] vec, input bit hold);
    bit got;
    got = 1'b0;
    par_data_i  = vec;
    par_valid_i = 1'b1;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk_i);
      if (par_ready_o) begin
        got = 1'b1;
        for (int k = 0; k < NB; k++) exp_q.push_back(vec[k*DW +: DW]);
      end
      @(posedge clk_i);
      #1;
    end
    if (!got) checkOutput("par_handshake_timeout", 32'd0, 32'd1);
    if (!hold) par_valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || m_busy) && c < 400) begin
      @(posedge clk_i);
      #1;
      c++;
    end
    if (c >= 400) checkOutput("drain_timeout", 32'd0, 32'd1);
    repeat (2) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [6:0] pat;
    int       n;
    logic [NB*DW-1:0] v;
    bit       hold;

    pat = 7'b1011001;
    repeat (3) @(posedge clk_i);
    #2;
    checkOutput("reset_ser_data", ser_data_o, 32'd0);
    checkOutput("reset_ser_last", {31'd0, ser_last_o}, 32'd0);
    checkOutput("reset_dut1_ready", {31'd0, p1_ready}, 32'd1);
    checkOutput("reset_dut1_valid", {31'd0, s1_valid}, 32'd0);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] basic");
    applyStimulus({32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
    waitDrain();

    $display("[TB] backpressure");
    rdy_mode = 3;
    ser_ready_i = 1'b1;
    applyStimulus({32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
    for (int i = 0; i < 7; i++) begin
      ser_ready_i = pat[i];
      @(posedge clk_i);
      #1;
    end
    ser_ready_i = 1'b1;
    rdy_mode = 0;
    waitDrain();

    $display("[TB] back-to-back");
    applyStimulus({32'd4, 32'd3, 32'd2, 32'd1}, 1'b1);
    applyStimulus({32'd8, 32'd7, 32'd6, 32'd5}, 1'b0);
    waitDrain();

    $display("[TB] clear mid-vector");
    applyStimulus({32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk_i);
      if (ser_valid_o && ser_ready_i) n++;
    end
    checkOutput("clear_beats_seen", n, 32'd2);
    @(posedge clk_i);
    #1 clear_i = 1'b1;
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    applyStimulus({32'hD, 32'hC, 32'hB, 32'hA}, 1'b0);
    waitDrain();

    $display("[TB] async reset mid-vector");
    rdy_mode = 3;
    ser_ready_i = 1'b0;
    applyStimulus({32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("areset_ser_valid", {31'd0, ser_valid_o}, 32'd0);
    checkOutput("areset_ser_data", ser_data_o, 32'd0);
    checkOutput("areset_par_ready", {31'd0, par_ready_o}, 32'd1);
    @(negedge clk_i);
    #2 rst_ni = 1'b1;
    ser_ready_i = 1'b1;
    rdy_mode = 0;
    @(posedge clk_i);
    #1;
    applyStimulus({32'h44, 32'h33, 32'h22, 32'h11}, 1'b0);
    waitDrain();

    $display("[TB] random");
    rdy_mode = 2;
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < NB; k++) v[k*DW +: DW] = $urandom;
      hold = (i < 19) && ($urandom_range(0, 1) == 1);
      applyStimulus(v, hold);
      if (!hold) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk_i);
          #1;
        end
      end
    end
    rdy_mode = 0;
    waitDrain();

    $display("[TB] single-element instance");
    p1_data  = 16'hCAFE;
    p1_valid = 1'b1;
    @(negedge clk_i);
    checkOutput("n1_par_ready", {31'd0, p1_ready}, 32'd1);
    @(posedge clk_i);
    #1 p1_valid = 1'b0;
    @(negedge clk_i);
    checkOutput("n1_ser_valid", {31'd0, s1_valid}, 32'd1);
    checkOutput("n1_ser_data", {16'd0, s1_data}, 32'h0000CAFE);
    checkOutput("n1_ser_last", {31'd0, s1_last}, 32'd1);
    checkOutput("n1_par_ready_busy", {31'd0, p1_ready}, 32'd0);
    checkOutput("n1_done_early", {31'd0, done1}, 32'd0);
    @(negedge clk_i);
    checkOutput("n1_done", {31'd0, done1}, 32'd1);
    checkOutput("n1_ser_valid_after", {31'd0, s1_valid}, 32'd0);
    checkOutput("n1_par_ready_after", {31'd0, p1_ready}, 32'd1);
    @(negedge clk_i);
    checkOutput("n1_done_pulse", {31'd0, done1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
